led_blink_arbiter: RTL and testbench

LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

---
 rtl/led_blink_arbiter.sv | 148 ++++++++++++++
 tb/tb_led_blink_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// Round-robin arbiter lending one shared LED to N_REQ requesters; each winner gets n on/off blinks, then a GAP idle.
// Latency: grant one clock after req is seen in IDLE; req is level-held until done, so no backpressure beyond waiting.
module led_blink_arbiter #(
  parameter int N_REQ = 4,
  parameter int DIV   = 5,
  parameter int GAP   = 10,
  parameter int CNT_W = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] blinks,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   led
);

  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMAX = (DIV > GAP) ? DIV : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DIV_LD = TW'(DIV - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt, done_nxt;
  logic             busy_nxt, led_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [IW-1:0]    last, last_nxt;

  logic             found;
  logic [IW-1:0]    win, cand;
  logic [N_REQ-1:0] win_oh;
  logic [CNT_W-1:0] cnt_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) cnt_arr[i] = blinks[i*CNT_W +: CNT_W];
  end

  // First requester after the last winner, wrapping; the last winner itself is checked last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << win;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    done_nxt  = '0;
    busy_nxt  = busy;
    led_nxt   = led;
    rem_nxt   = rem;
    timer_nxt = timer;
    last_nxt  = last;
    case (state)
      S_IDLE: begin
        if (found) begin
          last_nxt = win;
          rem_nxt  = cnt_arr[win];
          busy_nxt = 1'b1;
          if (cnt_arr[win] != '0) begin
            state_nxt = S_ON;
            grant_nxt = win_oh;
            led_nxt   = 1'b1;
            timer_nxt = DIV_LD;
          end else begin
            // Zero-count service: nothing to blink, report completion straight away.
            state_nxt = S_GAP;
            grant_nxt = '0;
            done_nxt  = win_oh;
            timer_nxt = GAP_LD;
          end
        end
      end
      S_ON: begin
        if (timer == '0) begin
          state_nxt = S_OFF;
          led_nxt   = 1'b0;
          timer_nxt = DIV_LD;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_OFF: begin
        if (timer == '0) begin
          rem_nxt = rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            state_nxt = S_GAP;
            grant_nxt = '0;
            done_nxt  = grant;
            timer_nxt = GAP_LD;
          end else begin
            state_nxt = S_ON;
            led_nxt   = 1'b1;
            timer_nxt = DIV_LD;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_GAP: begin
        if (timer == '0) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state <= S_IDLE;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      led   <= 1'b0;
      rem   <= '0;
      timer <= '0;
      last  <= IW'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
      led   <= led_nxt;
      rem   <= rem_nxt;
      timer <= timer_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter: service table plus reset corner sequences.
module tb_led_blink_arbiter;

  localparam int N   = 4;
  localparam int DIV = 5;
  localparam int GAP = 10;
  localparam int CW  = 4;

  logic          sys_clk = 1'b0;
  logic          sys_reset;
  logic [N-1:0]  req;
  logic [N*CW-1:0] blinks;
  logic [N-1:0]  grant, done;
  logic          busy, led;

  int checks = 0;
  int errors = 0;

  led_blink_arbiter #(.N_REQ(N), .DIV(DIV), .GAP(GAP), .CNT_W(CW)) dut (
    .sys_clk  (sys_clk),
    .sys_reset(sys_reset),
    .req      (req),
    .blinks   (blinks),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .led      (led)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [N-1:0]    req;
    logic [N*CW-1:0] blinks;
    logic [N-1:0]    g;
    int              n;
    int              drop;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [9:0] outs();
    return {led, busy, grant, done};
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s led/busy/grant/done got %b required %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One complete service starting at the grant edge and ending on the IDLE cycle after GAP.
  task automatic service(input string tag, input logic [N-1:0] g, input int n, input int drop);
    int lc;
    logic [9:0] e;
    lc = 2 * DIV * n;
    for (int s = 0; s <= lc + GAP; s++) begin
      tick();
      if (s < lc)            e = {((s / DIV) % 2) == 0, 1'b1, g, 4'b0000};
      else if (s == lc)      e = {1'b0, 1'b1, 4'b0000, g};
      else if (s < lc + GAP) e = {1'b0, 1'b1, 8'h00};
      else                   e = '0;
      chk($sformatf("%s s=%0d", tag, s), outs(), e);
      if (s == 0) blinks = ~blinks;
      if (s == drop) req = req & ~g;
    end
  endtask

  initial begin
    vecs[0]  = '{4'b1011, 16'h1111, 4'b0001, 1, -1};
    vecs[1]  = '{4'b1011, 16'h1111, 4'b0010, 1, -1};
    vecs[2]  = '{4'b1011, 16'h1111, 4'b1000, 1, -1};
    vecs[3]  = '{4'b1011, 16'h1111, 4'b0001, 1, -1};
    vecs[4]  = '{4'b1011, 16'h1111, 4'b0010, 1, -1};
    vecs[5]  = '{4'b0100, 16'h0300, 4'b0100, 3, -1};
    vecs[6]  = '{4'b0010, 16'h7605, 4'b0010, 0, -1};
    vecs[7]  = '{4'b0011, 16'h0021, 4'b0001, 1, -1};
    vecs[8]  = '{4'b0011, 16'h0021, 4'b0010, 2, 7};
    vecs[9]  = '{4'b1000, 16'hF000, 4'b1000, 15, -1};
    vecs[10] = '{4'b1111, 16'h1234, 4'b0001, 4, -1};

    sys_reset = 1'b0;
    req       = 4'b1111;
    blinks    = 16'hFFFF;
    #1;
    chk("reset t0", outs(), '0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("reset hold %0d", i), outs(), '0);
    end
    sys_reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req    = vecs[i].req;
      blinks = vecs[i].blinks;
      service($sformatf("vec%0d", i), vecs[i].g, vecs[i].n, vecs[i].drop);
    end

    // Reset asserted between edges during the second ON phase of a count-4 service.
    req    = 4'b1000;
    blinks = 16'h4000;
    tick();
    chk("midon grant", outs(), {1'b1, 1'b1, 4'b1000, 4'b0000});
    repeat (11) tick();
    chk("midon second on", outs(), {1'b1, 1'b1, 4'b1000, 4'b0000});
    #3;
    sys_reset = 1'b0;
    #1;
    chk("midon async clear", outs(), '0);
    tick();
    chk("midon held no done", outs(), '0);
    tick();
    chk("midon held 2", outs(), '0);
    req       = 4'b1001;
    blinks    = 16'h0002;
    sys_reset = 1'b1;
    service("post reset", 4'b0001, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
